boot_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of boot_rom.
- Drives the ROM word address, qualifies returned words with the ROM's data_valid, and buffers them in a small prefetch FIFO tagged with their PC for the decode stage.
- Handles redirects from downstream: flush the FIFO and refetch from the target.

---
 rtl/boot_fetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_boot_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_fetch_unit.sv
// boot_fetch_unit
//   Instruction fetch stage sitting directly in front of boot_rom. It drives
//   the ROM word address from a fetch PC register, accepts a returned word
//   only when the ROM flags it valid, and queues {pc, word} pairs in a small
//   prefetch FIFO for the decode stage. A redirect flushes the FIFO and
//   restarts fetching from a new PC.
//
// Optional feature (macro BOOT_FETCH_STATS_EN):
//   When defined, adds saturating 16-bit counters fetch_count (instructions
//   handed to the consumer) and stall_count (cycles spent in FULL). Both
//   clear on reset only. When undefined, the ports and counters are absent.
//
// Ports:
//   CLK            in   system clock
//   RSTb           in   asynchronous active-low reset
//   run            in   fetch enable; low freezes fetching, FIFO still drains
//   rom_addr       out  word address to boot_rom (registered fetch PC)
//   rom_data       in   boot_rom registered read data
//   rom_data_valid in   rom_data matches the current rom_addr
//   redirect       in   flush and refetch request
//   redirect_pc    in   new fetch address
//   instr          out  FIFO head instruction (0 when empty)
//   instr_pc       out  PC of FIFO head (0 when empty)
//   instr_valid    out  FIFO not empty
//   instr_ready    in   consumer accepts the head this cycle
//   fsm_state      out  debug view of the fetch FSM (0 START, 1 FETCH, 2 FULL)
//   fetch_count    out  [BOOT_FETCH_STATS_EN] saturating pop count
//   stall_count    out  [BOOT_FETCH_STATS_EN] saturating FULL-cycle count
//
// Handshake: the consumer takes the head on any rising edge where
// instr_valid and instr_ready are both high (and no redirect is being
// applied); instr_valid never depends on instr_ready.

module boot_fetch_unit #(
  parameter int          BITS            = 32,
  parameter int          ADDRESS_BITS    = 10,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned RESET_PC        = 0
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    run,
  output logic [ADDRESS_BITS-1:0] rom_addr,
  input  logic [BITS-1:0]         rom_data,
  input  logic                    rom_data_valid,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic [BITS-1:0]         instr,
  output logic [ADDRESS_BITS-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [1:0]              fsm_state
`ifdef BOOT_FETCH_STATS_EN
  ,
  output logic [15:0]             fetch_count,
  output logic [15:0]             stall_count
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]           DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]           DEPTH_M1   = CW'(DEPTH - 1);
  localparam logic [ADDRESS_BITS-1:0] RESET_PC_W = ADDRESS_BITS'(RESET_PC);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDRESS_BITS-1:0] fetch_pc_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  // Set for one cycle after a redirect so a rom_data_valid still belonging
  // to the pre-redirect address can never be captured.
  logic                    skip_q;

  logic [BITS-1:0]         fifo_instr [DEPTH];
  logic [ADDRESS_BITS-1:0] fifo_pc    [DEPTH];

  logic push, pop, full;

  assign full        = (count_q == DEPTH_C);
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign rom_addr    = fetch_pc_q;
  assign fsm_state   = state_q;

  // Head is presented straight from storage; forced to zero when empty so
  // the outputs are defined after reset.
  assign instr    = instr_valid ? fifo_instr[rd_ptr_q] : '0;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr_q]    : '0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_START: state_d = S_FETCH;
        S_FETCH: if (push && !pop && (count_q == DEPTH_M1)) state_d = S_FULL;
        S_FULL:  if (pop) state_d = S_FETCH;
        default: state_d = S_START;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // A push is allowed in FETCH when a slot is free now or is being freed by a
  // pop on the same edge. The redirect override happens in the datapath.
  always_comb begin
    push = 1'b0;
    case (state_q)
      S_FETCH: push = run & rom_data_valid & ~skip_q & (~full | pop);
      default: push = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch PC, pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      fetch_pc_q <= RESET_PC_W;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      skip_q     <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      skip_q     <= 1'b1;
    end else begin
      skip_q <= 1'b0;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        fetch_pc_q <= fetch_pc_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is read from a slot until it is written.
  always_ff @(posedge CLK) begin
    if (push && !redirect) begin
      fifo_instr[wr_ptr_q] <= rom_data;
      fifo_pc[wr_ptr_q]    <= fetch_pc_q;
    end
  end

`ifdef BOOT_FETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics (saturating, survive redirects)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop && !redirect && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if ((state_q == S_FULL) && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_boot_fetch_unit.sv
// tb_boot_fetch_unit
//   Directed bench for boot_fetch_unit with a behavioural boot_rom in front of
//   it. The ROM holds word (0xA0 + address) at every address, so
//   ROM[0x10]=0xB0, ROM[0x100]=0x1A0, ROM[0x3FE]=0x49E, ROM[0x3FF]=0x49F.
//   The driver pushes the {pc, instr} pairs it expects into exp_q; a monitor
//   pops and compares each time the consumer takes an instruction.

module tb_boot_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 32;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          run;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_data_valid;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    fsm_state;
`ifdef BOOT_FETCH_STATS_EN
  logic [15:0]   fetch_count;
  logic [15:0]   stall_count;
`endif

  boot_fetch_unit dut (
    .CLK            (clk),
    .RSTb           (rst_n),
    .run            (run),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_data_valid (rom_data_valid),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .fsm_state      (fsm_state)
`ifdef BOOT_FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // boot_rom model: registered data, valid once the address held for a cycle
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rom_mem [1 << AW];
  logic [AW-1:0] rom_prev;
  logic          rom_prev_ok;

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 32'(32'hA0 + i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_prev    <= '0;
      rom_prev_ok <= 1'b0;
      rom_data    <= '0;
    end else begin
      rom_prev    <= rom_addr;
      rom_prev_ok <= 1'b1;
      rom_data    <= rom_mem[rom_addr];
    end
  end

  assign rom_data_valid = rom_prev_ok && (rom_prev == rom_addr);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [AW+DW-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int seen       = 0;

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      compared++;
      seen++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no output", instr_pc, instr);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          mismatched++;
          $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc, instr, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_range(input logic [AW-1:0] first, input int n);
    logic [AW-1:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, rom_mem[a]});
      a = a + 1'b1;
    end
  endtask

  task automatic wait_seen(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (seen < target && n < budget) begin
      step();
      n++;
    end
    compared++;
    if (seen < target) begin
      mismatched++;
      $display("FAIL %s: got %0d outputs, required %0d", name, seen, target);
    end
  endtask

  task automatic chk_head(input string name, input logic v, input logic [AW-1:0] pc,
                          input logic [DW-1:0] d);
    chk({name, "_valid"}, 64'(instr_valid), 64'(v));
    if (v) begin
      chk({name, "_pc"}, 64'(instr_pc), 64'(pc));
      chk({name, "_instr"}, 64'(instr), 64'(d));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int base;

  initial begin
    rst_n       = 1'b0;
    run         = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state and first-fetch latency.
    expect_range(10'h000, 8);
    steps(2);
    @(negedge clk);
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_pc", 64'(instr_pc), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_state", 64'(fsm_state), 64'(ST_START));
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("c1_valid", 64'(instr_valid), 64'(0));
    chk("c1_state", 64'(fsm_state), 64'(ST_FETCH));
    step(); @(negedge clk);
    chk_head("c2_head", 1'b1, 10'h000, 32'hA0);
    step(); @(negedge clk);
    chk_head("c3_head", 1'b0, '0, '0);
    chk("c3_rom_addr", 64'(rom_addr), 64'(1));
    step(); @(negedge clk);
    chk_head("c4_head", 1'b1, 10'h001, 32'hA1);
    steps(2); @(negedge clk);
    chk_head("c6_head", 1'b1, 10'h002, 32'hA2);

    // Fill to FULL with the consumer stalled, then drain in order.
    step();
    redirect = 1'b1; redirect_pc = 10'h000; instr_ready = 1'b0;
    exp_q.delete();
    expect_range(10'h000, 16);
    step();
    redirect = 1'b0;
    steps(20); @(negedge clk);
    chk("full_state", 64'(fsm_state), 64'(ST_FULL));
    chk("full_rom_addr", 64'(rom_addr), 64'(4));
    chk_head("full_head", 1'b1, 10'h000, 32'hA0);
    step();
    instr_ready = 1'b1;
    base = seen;
    wait_seen("drain_full", base + 5, 40);

    // Redirect with three entries buffered.
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 10'h010;
    exp_q.delete();
    step();
    redirect = 1'b0;
    steps(5); @(negedge clk);
    chk_head("pre_redir_head", 1'b1, 10'h010, 32'hB0);
    step();
    redirect = 1'b1; redirect_pc = 10'h100; instr_ready = 1'b1;
    exp_q.delete();
    expect_range(10'h100, 8);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_p1_valid", 64'(instr_valid), 64'(0));
    step(); @(negedge clk);
    chk("redir_p1b_valid", 64'(instr_valid), 64'(0));
    step(); @(negedge clk);
    chk_head("redir_p2_head", 1'b1, 10'h100, 32'h1A0);

    // PC wrap-around.
    step();
    redirect = 1'b1; redirect_pc = 10'h3FE;
    exp_q.delete();
    expect_range(10'h3FE, 6);
    step();
    redirect = 1'b0;
    base = seen;
    wait_seen("wrap", base + 3, 30);

    // Reset in the middle of a full FIFO.
    instr_ready = 1'b0;
    steps(12); @(negedge clk);
    chk("prerst_state", 64'(fsm_state), 64'(ST_FULL));
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(instr_valid), 64'(0));
    chk("midrst_rom_addr", 64'(rom_addr), 64'(0));
    chk("midrst_state", 64'(fsm_state), 64'(ST_START));
    exp_q.delete();
    expect_range(10'h000, 4);
    instr_ready = 1'b1;
    steps(2);
    rst_n = 1'b1;
    base = seen;
    wait_seen("post_rst", base + 1, 20);

    // Counted scenario: 6 cycles in FULL, then exactly 10 pops.
    step();
    rst_n = 1'b0; instr_ready = 1'b0;
    exp_q.delete();
    expect_range(10'h000, 16);
    steps(2);
    rst_n = 1'b1;
    base = seen;
    steps(12); @(negedge clk);
    chk("stat_full_state", 64'(fsm_state), 64'(ST_FULL));
    chk("stat_full_addr", 64'(rom_addr), 64'(4));
    step();
    instr_ready = 1'b1;
    steps(13);
    instr_ready = 1'b0;
    @(negedge clk);
    chk("stat_pops", 64'(seen - base), 64'(10));
`ifdef BOOT_FETCH_STATS_EN
    chk("fetch_count", 64'(fetch_count), 64'(10));
    chk("stall_count", 64'(stall_count), 64'(6));
`endif
    step();
    redirect = 1'b1; redirect_pc = 10'h200;
    exp_q.delete();
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("post_redir_valid", 64'(instr_valid), 64'(0));
`ifdef BOOT_FETCH_STATS_EN
    chk("fetch_count_redir", 64'(fetch_count), 64'(10));
    chk("stall_count_redir", 64'(stall_count), 64'(6));
`endif

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
